// File: rtl/sat_pkg.sv
// Shared types for the clause-evaluation datapath.
package sat_pkg;
    `include "sysdefs.svh"

    localparam int NUM_LANES = `VAR_PER_CLAUSE;
    localparam int VAR_BITS  = `MAX_VARS_BITS;

    // One clause as stored in clause memory.
    typedef struct packed {
        logic [NUM_LANES-1:0]               mask;
        logic [NUM_LANES-1:0]               pole;
        logic [NUM_LANES-1:0][VAR_BITS-1:0] vars;
    } clause_entry_t;

    // Sweep scheduler states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } sched_state_e;
endpackage

// File: rtl/sub_clause_evaluator.sv
// Combinational evaluation of one clause against the current variable state.
// A literal is true when its variable is assigned and the value equals the
// literal's pole. The unit implication assigns the open variable the value
// equal to its pole, which makes that literal true.
module sub_clause_evaluator
    import sat_pkg::*;
(
    input  logic                          en,
    input  logic [NUM_LANES-1:0]          mask,
    input  logic [NUM_LANES-1:0]          pole,
    input  logic [NUM_LANES*VAR_BITS-1:0] vars,
    input  logic [NUM_LANES-1:0]          unassign,
    input  logic [NUM_LANES-1:0]          val,
    output logic                          conflict,
    output logic                          unit_clause,
    output logic [VAR_BITS-1:0]           implied_var,
    output logic                          new_val
);
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    logic [NUM_LANES-1:0] lit_true;
    logic [NUM_LANES-1:0] lit_open;
    logic [CNT_W-1:0]     open_cnt;

    // Classify each lane, count open literals and pick the open lane.
    always_comb begin
        lit_true    = mask & ~unassign & ~(val ^ pole);
        lit_open    = mask & unassign;
        open_cnt    = '0;
        implied_var = '0;
        new_val     = 1'b0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (lit_open[l]) begin
                open_cnt    = open_cnt + CNT_W'(1);
                implied_var = vars[l*VAR_BITS +: VAR_BITS];
                new_val     = pole[l];
            end
        end
        // An empty clause (mask = 0) is neither conflicting nor unit.
        conflict    = en && (mask != '0) && (lit_true == '0) && (lit_open == '0);
        unit_clause = en && (lit_true == '0) && (open_cnt == CNT_W'(1));
    end
endmodule

// File: rtl/sysdefs.svh
// System-wide widths shared by the SAT datapath.
`ifndef SYSDEFS_SVH
`define SYSDEFS_SVH

// Literal lanes per clause.
`define VAR_PER_CLAUSE 5
// Width of a variable id.
`define MAX_VARS_BITS  8

`endif

// File: rtl/clause_eval_scheduler.sv
// Runs one BCP sweep over clause memory through a 3-stage pipeline:
//   S0 issues the clause read, S1 issues the variable-state read from the
//   returned literal ids, S2 evaluates the clause.
// Unit implications leave through imp_valid/imp_ready: imp_valid holds with
// stable data until the cycle both imp_valid and imp_ready are high. A unit
// result arriving while the output register is occupied and not being
// accepted stalls issue, S1 and S2; both memories hold their data while their
// read enable is low, so stalled stages see unchanged read data.
// The first conflict squashes S0/S1 and ends the sweep after the output
// register drains.
module clause_eval_scheduler
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 64,
    parameter int CLAUSE_BITS = $clog2(NUM_CLAUSES)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          conflict,
    output logic [CLAUSE_BITS-1:0]        conflict_clause,
    output logic                          cl_rd_en,
    output logic [CLAUSE_BITS-1:0]        cl_rd_addr,
    input  logic [NUM_LANES-1:0]          cl_mask,
    input  logic [NUM_LANES-1:0]          cl_pole,
    input  logic [NUM_LANES*VAR_BITS-1:0] cl_vars,
    output logic                          vs_rd_en,
    output logic [NUM_LANES*VAR_BITS-1:0] vs_rd_addr,
    input  logic [NUM_LANES-1:0]          vs_unassign,
    input  logic [NUM_LANES-1:0]          vs_val,
    output logic                          imp_valid,
    input  logic                          imp_ready,
    output logic [VAR_BITS-1:0]           imp_var,
    output logic                          imp_val,
    output logic [CLAUSE_BITS-1:0]        imp_clause
);
    sched_state_e state, state_nxt;

    logic [CLAUSE_BITS-1:0] issue_cnt;
    logic                   s1_valid;
    logic [CLAUSE_BITS-1:0] s1_idx;
    logic                   s2_valid;
    logic [CLAUSE_BITS-1:0] s2_idx;
    clause_entry_t          s2_entry;

    logic                   ev_conflict;
    logic                   ev_unit;
    logic [VAR_BITS-1:0]    ev_var;
    logic                   ev_val;

    logic                   s2_conflict;
    logic                   s2_unit;
    logic                   imp_free;
    logic                   stall;
    logic                   issue;
    logic                   last_issue;
    logic                   pipe_empty;
    logic                   start_sweep;

    sub_clause_evaluator u_eval (
        .en          (s2_valid),
        .mask        (s2_entry.mask),
        .pole        (s2_entry.pole),
        .vars        (s2_entry.vars),
        .unassign    (vs_unassign),
        .val         (vs_val),
        .conflict    (ev_conflict),
        .unit_clause (ev_unit),
        .implied_var (ev_var),
        .new_val     (ev_val)
    );

    // Pipeline control: stall, issue and squash decisions for this cycle.
    always_comb begin
        s2_conflict = s2_valid && ev_conflict;
        s2_unit     = s2_valid && ev_unit && !ev_conflict;
        imp_free    = !imp_valid || imp_ready;
        stall       = s2_unit && !imp_free;
        issue       = (state == S_RUN) && !stall && !s2_conflict;
        last_issue  = issue && (issue_cnt == CLAUSE_BITS'(NUM_CLAUSES - 1));
        pipe_empty  = !s1_valid && !s2_valid && !imp_valid;
        cl_rd_en    = issue;
        cl_rd_addr  = issue ? issue_cnt : '0;
        vs_rd_en    = s1_valid && !stall && !s2_conflict;
        vs_rd_addr  = vs_rd_en ? cl_vars : '0;
    end

    // Sweep FSM next-state and status outputs.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        start_sweep = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_sweep = 1'b1;
                    state_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_issue || s2_conflict) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sweep FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clause issue counter: cleared on start, advances on each issued read.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            issue_cnt <= '0;
        end else if (start_sweep) begin
            issue_cnt <= '0;
        end else if (issue) begin
            issue_cnt <= issue_cnt + CLAUSE_BITS'(1);
        end
    end

    // S1/S2 stage registers: advance unless stalled, cleared by a conflict.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_entry <= '0;
        end else if (s2_conflict) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid       <= issue;
            s1_idx         <= issue_cnt;
            s2_valid       <= s1_valid;
            s2_idx         <= s1_idx;
            s2_entry.mask  <= cl_mask;
            s2_entry.pole  <= cl_pole;
            s2_entry.vars  <= cl_vars;
        end
    end

    // Conflict result: cleared at sweep start, latched on the first conflict.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            conflict        <= 1'b0;
            conflict_clause <= '0;
        end else if (start_sweep) begin
            conflict        <= 1'b0;
            conflict_clause <= '0;
        end else if (s2_conflict) begin
            conflict        <= 1'b1;
            conflict_clause <= s2_idx;
        end
    end

    // Implication output register: load on a unit when free, clear on accept.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            imp_valid  <= 1'b0;
            imp_var    <= '0;
            imp_val    <= 1'b0;
            imp_clause <= '0;
        end else if (s2_unit && imp_free) begin
            imp_valid  <= 1'b1;
            imp_var    <= ev_var;
            imp_val    <= ev_val;
            imp_clause <= s2_idx;
        end else if (imp_valid && imp_ready) begin
            imp_valid  <= 1'b0;
        end
    end
endmodule
